// File: rtl/rs_entry_alloc.sv
// Reservation-station entry allocator: keeps the RS busy vector and grants
// up to two free entries per cycle (lowest free to slot 1, highest free to slot 2).
module rs_entry_alloc #(
    parameter int ENTSEL = 3,
    parameter int ENTNUM = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req1,
    input  logic              req2,
    input  logic              stall_dp,
    output logic              alloc_ok,
    output logic [ENTSEL-1:0] alloc_ent1,
    output logic [ENTSEL-1:0] alloc_ent2,
    output logic              alloc_fire,
    input  logic              free_en,
    input  logic [ENTSEL-1:0] free_ent,
    input  logic [ENTNUM-1:0] kill_vec,
    output logic [ENTNUM-1:0] busy_vec,
    output logic [ENTSEL:0]   free_cnt,
    output logic              err_free
);

    logic [ENTNUM-1:0] busy_reg, busy_next;
    logic [ENTNUM-1:0] free_vec, free_dec, ent1_oh, ent2_oh, set_vec, clr_vec;
    logic [ENTSEL:0]   free_cnt_reg, free_cnt_next;
    logic              err_reg, err_next;
    logic [1:0]        req_cnt;
    logic              bad_free;

    assign free_vec = ~busy_reg;

    // Priority scans: the last match wins, so scanning downward yields the
    // lowest free index and scanning upward yields the highest.
    always_comb begin
        alloc_ent1 = '0;
        alloc_ent2 = '0;
        for (int i = ENTNUM - 1; i >= 0; i--) begin
            if (free_vec[i]) alloc_ent1 = ENTSEL'(i);
        end
        for (int i = 0; i < ENTNUM; i++) begin
            if (free_vec[i]) alloc_ent2 = ENTSEL'(i);
        end
    end

    assign req_cnt    = {1'b0, req1} + {1'b0, req2};
    assign alloc_ok   = (req_cnt == 2'd0) ||
                        (free_cnt_reg >= {{(ENTSEL-1){1'b0}}, req_cnt});
    assign alloc_fire = (req_cnt != 2'd0) && alloc_ok && !stall_dp &&
                        (kill_vec == '0);

    generate
        for (genvar gi = 0; gi < ENTNUM; gi++) begin : g_ent
            assign free_dec[gi]  = (free_ent == ENTSEL'(gi));
            assign ent1_oh[gi]   = (alloc_ent1 == ENTSEL'(gi));
            assign ent2_oh[gi]   = (alloc_ent2 == ENTSEL'(gi));
            // A lone req2 is served on slot 1, so slot 2 only sets with both requests.
            assign set_vec[gi]   = alloc_fire &&
                                   (ent1_oh[gi] || (req1 && req2 && ent2_oh[gi]));
            assign clr_vec[gi]   = kill_vec[gi] ||
                                   (free_en && busy_reg[gi] && free_dec[gi]);
            assign busy_next[gi] = (busy_reg[gi] || set_vec[gi]) && !clr_vec[gi];
        end
    endgenerate

    // Out-of-range indices match no decode bit, so they also flag an error.
    assign bad_free = free_en && !(|(busy_reg & free_dec));
    assign err_next = err_reg || bad_free;

    always_comb begin
        free_cnt_next = (ENTSEL+1)'(ENTNUM);
        for (int i = 0; i < ENTNUM; i++) begin
            free_cnt_next = free_cnt_next - (ENTSEL+1)'(busy_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg     <= '0;
            free_cnt_reg <= (ENTSEL+1)'(ENTNUM);
            err_reg      <= 1'b0;
        end else begin
            busy_reg     <= busy_next;
            free_cnt_reg <= free_cnt_next;
            err_reg      <= err_next;
        end
    end

    assign busy_vec = busy_reg;
    assign free_cnt = free_cnt_reg;
    assign err_free = err_reg;

endmodule

// File: tb/tb_rs_entry_alloc.sv
// Directed bench for rs_entry_alloc: hand-computed vectors per scenario.
module tb_rs_entry_alloc;

    logic       clk = 1'b0;
    logic       reset, req1, req2, stall_dp, free_en;
    logic [2:0] free_ent;
    logic [7:0] kill_vec;
    logic       alloc_ok, alloc_fire, err_free;
    logic [2:0] alloc_ent1, alloc_ent2;
    logic [7:0] busy_vec;
    logic [3:0] free_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rs_entry_alloc #(.ENTSEL(3), .ENTNUM(8)) dut (
        .clk(clk), .reset(reset), .req1(req1), .req2(req2), .stall_dp(stall_dp),
        .alloc_ok(alloc_ok), .alloc_ent1(alloc_ent1), .alloc_ent2(alloc_ent2),
        .alloc_fire(alloc_fire), .free_en(free_en), .free_ent(free_ent),
        .kill_vec(kill_vec), .busy_vec(busy_vec), .free_cnt(free_cnt),
        .err_free(err_free)
    );

    // Apply inputs on the falling edge and let combinational outputs settle.
    task automatic drive(input logic rs, input logic r1, input logic r2, input logic st,
                         input logic fe, input logic [2:0] fent, input logic [7:0] kv);
        @(negedge clk);
        reset = rs; req1 = r1; req2 = r2; stall_dp = st;
        free_en = fe; free_ent = fent; kill_vec = kv;
        #1;
        $display("[%0t] rst=%b req=%b%b stall=%b free=%b/%0d kill=%h -> ok=%b e1=%0d e2=%0d fire=%b busy=%h cnt=%0d err=%b",
                 $time, rs, r1, r2, st, fe, fent, kv, alloc_ok, alloc_ent1, alloc_ent2,
                 alloc_fire, busy_vec, free_cnt, err_free);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(1, 0, 0, 0, 0, 0, 8'h00); tick();
        drive(0, 0, 0, 0, 0, 0, 8'h00);
        vectors++; if (busy_vec !== 8'h00) begin miscompares++; $display("FAIL rst_busy got=%h want=00", busy_vec); end
        vectors++; if (free_cnt !== 4'd8) begin miscompares++; $display("FAIL rst_cnt got=%0d want=8", free_cnt); end
        vectors++; if (err_free !== 1'b0) begin miscompares++; $display("FAIL rst_err got=%b want=0", err_free); end
        vectors++; if (alloc_ent1 !== 3'd0 || alloc_ent2 !== 3'd7) begin miscompares++; $display("FAIL rst_ents got=%0d/%0d want=0/7", alloc_ent1, alloc_ent2); end
        vectors++; if (alloc_ok !== 1'b1 || alloc_fire !== 1'b0) begin miscompares++; $display("FAIL rst_idle got ok=%b fire=%b want 1/0", alloc_ok, alloc_fire); end
    endtask

    task automatic test_dual_alloc;
        drive(0, 1, 1, 0, 0, 0, 8'h00);
        vectors++; if (alloc_ok !== 1'b1 || alloc_fire !== 1'b1) begin miscompares++; $display("FAIL dual_okfire got=%b/%b want=1/1", alloc_ok, alloc_fire); end
        vectors++; if (alloc_ent1 !== 3'd0 || alloc_ent2 !== 3'd7) begin miscompares++; $display("FAIL dual_ents got=%0d/%0d want=0/7", alloc_ent1, alloc_ent2); end
        tick();
        vectors++; if (busy_vec !== 8'h81 || free_cnt !== 4'd6) begin miscompares++; $display("FAIL dual_state got=%h/%0d want=81/6", busy_vec, free_cnt); end
    endtask

    task automatic test_stall;
        drive(0, 1, 1, 1, 0, 0, 8'h00);
        vectors++; if (alloc_ok !== 1'b1 || alloc_fire !== 1'b0) begin miscompares++; $display("FAIL stall_okfire got=%b/%b want=1/0", alloc_ok, alloc_fire); end
        vectors++; if (alloc_ent1 !== 3'd1 || alloc_ent2 !== 3'd6) begin miscompares++; $display("FAIL stall_ents got=%0d/%0d want=1/6", alloc_ent1, alloc_ent2); end
        tick();
        vectors++; if (busy_vec !== 8'h81 || free_cnt !== 4'd6) begin miscompares++; $display("FAIL stall_state got=%h/%0d want=81/6", busy_vec, free_cnt); end
    endtask

    task automatic test_fill;
        drive(0, 1, 1, 0, 0, 0, 8'h00); tick();
        vectors++; if (busy_vec !== 8'hC3 || free_cnt !== 4'd4) begin miscompares++; $display("FAIL fill1 got=%h/%0d want=C3/4", busy_vec, free_cnt); end
        drive(0, 1, 1, 0, 0, 0, 8'h00);
        vectors++; if (alloc_ent1 !== 3'd2 || alloc_ent2 !== 3'd5) begin miscompares++; $display("FAIL fill2_ents got=%0d/%0d want=2/5", alloc_ent1, alloc_ent2); end
        tick();
        drive(0, 1, 1, 0, 0, 0, 8'h00);
        vectors++; if (alloc_ok !== 1'b1 || alloc_fire !== 1'b1 || alloc_ent1 !== 3'd3 || alloc_ent2 !== 3'd4) begin
            miscompares++; $display("FAIL fill_last2 got ok=%b fire=%b e=%0d/%0d want 1/1 3/4", alloc_ok, alloc_fire, alloc_ent1, alloc_ent2); end
        tick();
        vectors++; if (busy_vec !== 8'hFF || free_cnt !== 4'd0) begin miscompares++; $display("FAIL fill_full got=%h/%0d want=FF/0", busy_vec, free_cnt); end
    endtask

    task automatic test_full_free;
        drive(0, 1, 0, 0, 1, 3'd4, 8'h00);
        vectors++; if (alloc_ok !== 1'b0 || alloc_fire !== 1'b0) begin miscompares++; $display("FAIL full_okfire got=%b/%b want=0/0", alloc_ok, alloc_fire); end
        vectors++; if (alloc_ent1 !== 3'd0 || alloc_ent2 !== 3'd0) begin miscompares++; $display("FAIL full_ents got=%0d/%0d want=0/0", alloc_ent1, alloc_ent2); end
        tick();
        vectors++; if (busy_vec !== 8'hEF || free_cnt !== 4'd1) begin miscompares++; $display("FAIL full_free got=%h/%0d want=EF/1", busy_vec, free_cnt); end
        drive(0, 1, 0, 0, 0, 0, 8'h00);
        vectors++; if (alloc_ent1 !== 3'd4 || alloc_ent2 !== 3'd4 || alloc_fire !== 1'b1) begin miscompares++; $display("FAIL realloc4 got=%0d/%0d fire=%b want=4/4 1", alloc_ent1, alloc_ent2, alloc_fire); end
        tick();
        vectors++; if (busy_vec !== 8'hFF || free_cnt !== 4'd0) begin miscompares++; $display("FAIL realloc4_state got=%h/%0d want=FF/0", busy_vec, free_cnt); end
    endtask

    task automatic test_one_free;
        drive(0, 0, 0, 0, 1, 3'd2, 8'h00); tick();
        drive(0, 1, 1, 0, 0, 0, 8'h00);
        vectors++; if (busy_vec !== 8'hFB || free_cnt !== 4'd1) begin miscompares++; $display("FAIL one_state got=%h/%0d want=FB/1", busy_vec, free_cnt); end
        vectors++; if (alloc_ok !== 1'b0 || alloc_fire !== 1'b0) begin miscompares++; $display("FAIL one_dual got=%b/%b want=0/0", alloc_ok, alloc_fire); end
        vectors++; if (alloc_ent1 !== 3'd2 || alloc_ent2 !== 3'd2) begin miscompares++; $display("FAIL one_ents got=%0d/%0d want=2/2", alloc_ent1, alloc_ent2); end
        tick();
        drive(0, 1, 0, 0, 0, 0, 8'h00);
        vectors++; if (busy_vec !== 8'hFB || alloc_fire !== 1'b1) begin miscompares++; $display("FAIL one_single got=%h fire=%b want=FB 1", busy_vec, alloc_fire); end
        tick();
        vectors++; if (busy_vec !== 8'hFF || free_cnt !== 4'd0) begin miscompares++; $display("FAIL one_full got=%h/%0d want=FF/0", busy_vec, free_cnt); end
        drive(0, 0, 0, 0, 1, 3'd2, 8'h00); tick();
        drive(0, 0, 1, 0, 0, 0, 8'h00);
        vectors++; if (alloc_fire !== 1'b1 || alloc_ent1 !== 3'd2) begin miscompares++; $display("FAIL req2only got fire=%b e1=%0d want 1/2", alloc_fire, alloc_ent1); end
        tick();
        vectors++; if (busy_vec !== 8'hFF || free_cnt !== 4'd0) begin miscompares++; $display("FAIL req2only_state got=%h/%0d want=FF/0", busy_vec, free_cnt); end
    endtask

    task automatic test_kill;
        drive(1, 0, 0, 0, 0, 0, 8'h00); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 0, 0, 8'h00); tick();
        end
        drive(0, 1, 1, 0, 0, 0, 8'h06);
        vectors++; if (busy_vec !== 8'h0F || alloc_fire !== 1'b0 || alloc_ok !== 1'b1) begin
            miscompares++; $display("FAIL kill_block got busy=%h fire=%b ok=%b want 0F 0 1", busy_vec, alloc_fire, alloc_ok); end
        tick();
        vectors++; if (busy_vec !== 8'h09 || free_cnt !== 4'd6) begin miscompares++; $display("FAIL kill_state got=%h/%0d want=09/6", busy_vec, free_cnt); end
        drive(0, 0, 0, 0, 1, 3'd0, 8'h01); tick();
        vectors++; if (busy_vec !== 8'h08 || free_cnt !== 4'd7 || err_free !== 1'b0) begin
            miscompares++; $display("FAIL kill_free got=%h/%0d err=%b want 08/7 0", busy_vec, free_cnt, err_free); end
    endtask

    task automatic test_err_free;
        drive(1, 0, 0, 0, 0, 0, 8'h00); tick();
        drive(0, 1, 0, 0, 0, 0, 8'h00); tick();
        drive(0, 0, 0, 0, 1, 3'd5, 8'h00); tick();
        vectors++; if (err_free !== 1'b1 || busy_vec !== 8'h01 || free_cnt !== 4'd7) begin
            miscompares++; $display("FAIL err_set got err=%b busy=%h cnt=%0d want 1 01 7", err_free, busy_vec, free_cnt); end
        drive(0, 0, 0, 0, 0, 0, 8'h00); tick(); tick();
        vectors++; if (err_free !== 1'b1 || busy_vec !== 8'h01) begin miscompares++; $display("FAIL err_sticky got err=%b busy=%h want 1 01", err_free, busy_vec); end
    endtask

    task automatic test_reset_priority;
        drive(1, 0, 0, 0, 0, 0, 8'h00); tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 0, 0, 0, 8'h00); tick();
        end
        drive(0, 0, 0, 0, 1, 3'd0, 8'h00); tick();
        drive(0, 0, 0, 0, 1, 3'd1, 8'h00); tick();
        drive(0, 0, 0, 0, 1, 3'd7, 8'h00); tick();
        vectors++; if (busy_vec !== 8'h3C || err_free !== 1'b1 || free_cnt !== 4'd4) begin
            miscompares++; $display("FAIL prio_setup got busy=%h err=%b cnt=%0d want 3C 1 4", busy_vec, err_free, free_cnt); end
        drive(1, 1, 1, 0, 0, 0, 8'h00); tick();
        drive(0, 0, 0, 0, 0, 0, 8'h00);
        vectors++; if (busy_vec !== 8'h00 || free_cnt !== 4'd8 || err_free !== 1'b0) begin
            miscompares++; $display("FAIL prio_reset got busy=%h cnt=%0d err=%b want 00 8 0", busy_vec, free_cnt, err_free); end
    endtask

    initial begin
        reset = 1'b1; req1 = 1'b0; req2 = 1'b0; stall_dp = 1'b0;
        free_en = 1'b0; free_ent = 3'd0; kill_vec = 8'h00;
        test_reset();
        test_dual_alloc();
        test_stall();
        test_fill();
        test_full_free();
        test_one_free();
        test_kill();
        test_err_free();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rs_entry_alloc.md
Name: rs_entry_alloc

Overview:
Reservation-station entry allocator that sits directly upstream of the issue-select encoders, in the dispatch stage. Tracks the busy vector of one RS and picks up to two free entries per cycle: lowest-index free for slot 1, highest-index free for slot 2. Frees entries on issue and clears entries on branch-mispredict kill. Drives the registered busy vector consumed by the downstream entry-search logic.

Parameters:
ENTSEL, 3, index width; must satisfy 2^ENTSEL >= ENTNUM
ENTNUM, 8, number of RS entries

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
req1  in  1  dispatch slot 1 requests an entry
req2  in  1  dispatch slot 2 requests an entry
stall_dp  in  1  dispatch stalled elsewhere; suppresses allocation
alloc_ok  out  1  enough free entries for the current request set
alloc_ent1  out  ENTSEL  entry granted to slot 1
alloc_ent2  out  ENTSEL  entry granted to slot 2
alloc_fire  out  1  allocation commits at the next edge
free_en  in  1  issue frees one entry this cycle
free_ent  in  ENTSEL  entry being freed
kill_vec  in  ENTNUM  entries to clear on mispredict (bitmask)
busy_vec  out  ENTNUM  registered busy bits
free_cnt  out  ENTSEL+1  registered count of free entries
err_free  out  1  sticky: a non-busy entry was freed

Behaviour:
- Reset, synchronous and active-high:
  - busy_vec=0, free_cnt=ENTNUM, err_free=0.
  - Combinational outputs follow the reset state: alloc_ent1=0, alloc_ent2=ENTNUM-1.
  - Reset has priority over every other input in the same cycle.
- Entry selection is combinational on the registered busy_vec (free = ~busy_vec):
  - alloc_ent1 = lowest free index.
  - alloc_ent2 = highest free index.
  - With no free entry, both outputs are 0.
  - With exactly one free entry, both outputs give the same index.
- Request count n = req1 + req2.
  - req2 without req1 is treated as a single request served on alloc_ent1; alloc_ent2 is unused.
- alloc_ok = (n==0) | (free_cnt >= n).
  - Depends only on the registered state, never on same-cycle frees or kills.
- alloc_fire = (n!=0) & alloc_ok & ~stall_dp & (kill_vec==0).
- Next-state update at the edge, applied in this order:
  1. set = (alloc_fire ? chosen entries : 0).
  2. clr = kill_vec | (free_en ? onehot(free_ent) : 0).
  3. busy_next = (busy_vec | set) & ~clr.
- A freed or killed entry is never reallocated in the same cycle, because selection uses the pre-edge busy_vec. Set and clr therefore never target the same new entry.
- free_cnt is registered and equals ENTNUM - popcount(busy_next); no separate counter may drift.
- err_free:
  - Sets when free_en=1 and busy_vec[free_ent]=0, or free_ent >= ENTNUM.
  - Such a free changes no busy bit.
  - Clears only on reset.
- Kill:
  - Any nonzero kill_vec blocks that cycle's allocation, since the dispatched instructions are on the wrong path.
  - A killed entry that is also the free target is cleared once, with no error.
- Latency:
  - Grant indices are visible in the request cycle.
  - busy_vec and free_cnt reflect the change one cycle later.
- No state changes when n==0, free_en=0 and kill_vec=0.

Test Plan:
- Reset then req1=req2=1, stall_dp=0 -> alloc_ok=1, ent1=0, ent2=7, alloc_fire=1; next cycle busy_vec=8'b1000_0001, free_cnt=6.
- busy_vec=8'b1111_1011, req1=req2=1 -> alloc_ok=0, alloc_fire=0, ent1=ent2=2. With req1 only -> fire; next cycle busy_vec=8'hFF, free_cnt=0.
- busy_vec=8'hFF, free_en=1 free_ent=4, req1=1 in the same cycle -> alloc_ok=0, no allocation; next cycle busy_vec=8'hEF, free_cnt=1. Following cycle req1 -> ent1=4.
- busy_vec=8'h0F, kill_vec=8'h06, req1=req2=1 -> alloc_fire=0; next cycle busy_vec=8'h09, free_cnt=6.
- busy_vec=8'h01, free_en=1 free_ent=5 -> err_free=1 next cycle, busy_vec unchanged at 8'h01; err_free stays 1 until reset.
- Allocation in progress with busy_vec=8'h3C and req1=req2=1, reset=1 -> next cycle busy_vec=0, free_cnt=8, err_free=0, no allocation committed.
